// File: rtl/keccak_arbiter.sv
// keccak_arbiter: two-requester arbiter sharing one KeccakF1600 core, with round-robin priority and a WAIT timeout
module keccak_arbiter #(
  parameter int STATE_WIDTH = 1600,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic [STATE_WIDTH-1:0] state0_in,
  input  logic                   req1,
  input  logic [STATE_WIDTH-1:0] state1_in,
  output logic                   kf_start,
  output logic [STATE_WIDTH-1:0] kf_state_in,
  input  logic [STATE_WIDTH-1:0] kf_state_out,
  input  logic                   kf_done,
  output logic                   ack0,
  output logic                   ack1,
  output logic [STATE_WIDTH-1:0] state_out,
  output logic                   err,
  output logic                   busy,
  output logic                   grant_id,
  output logic [1:0]             debug_arb_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic prio_q, prio_d, gid_q, gid_d, tout_q, tout_d;
  logic [7:0] timer_q, timer_d;
  logic [STATE_WIDTH-1:0] kin_q, kin_d, sout_q, sout_d;
  // next-state: grant in IDLE, time the core in WAIT, rotate priority in RESP
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gid_d   = gid_q;
    tout_d  = tout_q;
    timer_d = timer_q;
    kin_d   = kin_q;
    sout_d  = sout_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        gid_d   = (req0 & req1) ? prio_q : req1;
        kin_d   = gid_d ? state1_in : state0_in;
        state_d = START;
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (kf_done) begin
        sout_d  = kf_state_out;
        tout_d  = 1'b0;
        state_d = RESP;
      end else if (timer_q == TLIM) begin
        tout_d  = 1'b1;
        state_d = RESP;
      end else begin
        timer_d = timer_q + 8'd1;
      end
      RESP: begin
        prio_d  = ~gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; active-low synchronous reset aborts any job in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      tout_q  <= 1'b0;
      timer_q <= '0;
      kin_q   <= '0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      tout_q  <= tout_d;
      timer_q <= timer_d;
      kin_q   <= kin_d;
      sout_q  <= sout_d;
    end
  end
  assign kf_start        = state_q == START;
  assign busy            = state_q != IDLE;
  assign ack0            = (state_q == RESP) && !gid_q;
  assign ack1            = (state_q == RESP) && gid_q;
  assign err             = (state_q == RESP) && tout_q;
  assign grant_id        = gid_q;
  assign debug_arb_state = state_q;
  assign kf_state_in     = kin_q;
  assign state_out       = sout_q;
endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 Parameter: STATE_WIDTH, 1600, width of the Keccak state bus.
REQ-002 Parameter: TIMEOUT, 64, max WAIT cycles for kf_done; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 req0  input  1  requester 0 permutation request, level.
REQ-006 state0_in  input  STATE_WIDTH  requester 0 state; stable while req0 high.
REQ-007 req1  input  1  requester 1 permutation request, level.
REQ-008 state1_in  input  STATE_WIDTH  requester 1 state; stable while req1 high.
REQ-009 kf_start  output  1  one-cycle start pulse to the shared KeccakF1600 core.
REQ-010 kf_state_in  output  STATE_WIDTH  registered state driven to core.
REQ-011 kf_state_out  input  STATE_WIDTH  core result.
REQ-012 kf_done  input  1  core completion, one-cycle pulse.
REQ-013 ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-014 state_out  output  STATE_WIDTH  registered result; valid in the ack cycle.
REQ-015 err  output  1  high with the ack pulse when the job timed out.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_id  output  1  requester currently/last served.
REQ-018 debug_arb_state  output  2  FSM encoding: IDLE=0, START=1, WAIT=2, RESP=3.

Function
REQ-019 FSM: IDLE -> START -> WAIT -> RESP -> IDLE; no other transitions except reset.
REQ-020 IDLE: if req0|req1, select winner, register selected stateN_in into kf_state_in, set grant_id, go START; else stay.
REQ-021 Arbitration: single request wins outright; both high -> winner = prio pointer (0 favours req0, 1 favours req1).
REQ-022 prio updated in RESP only: prio <= ~grant_id (served requester becomes lowest priority).
REQ-023 START: kf_start=1 for exactly this cycle; timer cleared to 0; go WAIT.
REQ-024 WAIT: kf_done=1 -> state_out <= kf_state_out, timeout flag <= 0, go RESP.
REQ-025 WAIT: kf_done=0 -> timer+1; when timer reaches TIMEOUT-1 without kf_done, timeout flag <= 1, state_out unchanged, go RESP.
REQ-026 kf_done and the timeout limit in the same cycle -> kf_done wins (no error).
REQ-027 kf_done outside WAIT is ignored; no state or output change.
REQ-028 RESP: ack[grant_id]=1 for exactly one cycle, err=timeout flag, other ack 0; go IDLE.
REQ-029 Latency: req sampled in IDLE cycle t -> kf_start at t+1; kf_done sampled at cycle d -> ack at d+1; minimum request-to-ack 4 cycles (kf_done at t+2).
REQ-030 Requests are sampled only in IDLE; req changes in START/WAIT/RESP have no effect.
REQ-031 A requester still holding req after its ack is re-arbitrated in the next IDLE cycle under the updated prio.
REQ-032 kf_state_in holds its value from grant through RESP; changes only on a new grant.
REQ-033 At most one job in flight; no queuing beyond the two req lines.

Reset
REQ-034 reset=0 at a clock edge -> FSM IDLE, prio=0, timer=0, timeout flag=0, grant_id=0.
REQ-035 Reset values: kf_start=0, ack0=0, ack1=0, err=0, busy=0, kf_state_in=0, state_out=0, debug_arb_state=0.
REQ-036 Reset mid-job (START/WAIT/RESP) aborts it: no ack issued, kf_start 0 from the next cycle, later kf_done ignored.

Verification
REQ-037 Single req0, state0_in=1600'h1, core returns 1600'hA5 with kf_done 3 cycles after kf_start -> kf_start 1 cycle, ack0 at kf_done+1, state_out=1600'hA5, err=0.
REQ-038 req0 and req1 high together from reset, held -> grant order 0,1,0,1; ack0/ack1 alternate; never two acks in one cycle.
REQ-039 TIMEOUT=4, kf_done never asserted -> ack pulse 4 WAIT cycles after kf_start with err=1, state_out unchanged from the prior value.
REQ-040 kf_done pulsed in IDLE and in START -> ignored; job completes only on a kf_done seen in WAIT.
REQ-041 reset=0 asserted for one cycle in WAIT -> busy=0 next cycle, no ack; subsequent kf_done ignored; next req0 served with prio=0.
REQ-042 req1 dropped during WAIT after grant -> job still completes with ack1; req1 is not re-served.
